booth_controller: RTL and testbench

Control unit for the 6-bit radix-2 Booth multiplier. It sits directly upstream of the multiplier datapath and drives all of its load, shift and clear strobes. It produces the signed addend `x_adder` (0, +x or −x) from the multiplier's low Booth pair, and sequences six add/shift iterations. It exposes a start/ready/done handshake to the issuing logic.

---
 rtl/booth_controller.sv | 127 ++++++++++++
 tb/tb_booth_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_controller.sv
// Control unit for a 6-bit radix-2 Booth multiplier: sequences load/add/shift strobes.
// Optional BOOTH_ZERO_SKIP_EN: iterations with a 00/11 Booth pair skip the add cycle.
module booth_controller #(
  parameter int unsigned N_BITS = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [N_BITS-1:0] i_x,
  input  logic [1:0]        i_y_pair,
  output logic              o_ldx,
  output logic              o_ldy,
  output logic              o_rst_p,
  output logic              o_ldp,
  output logic              o_shift_y,
  output logic              o_shift_p,
  output logic [N_BITS-1:0] o_x_adder,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf
);

  typedef enum logic [2:0] {StIdle, StLoad, StAdd, StShift, StDone} state_e;

  localparam logic [2:0]        LastIter = 3'(N_BITS - 1);
  localparam logic [N_BITS-1:0] MinNeg   = {1'b1, {(N_BITS-1){1'b0}}};
  localparam logic [N_BITS-1:0] One      = {{(N_BITS-1){1'b0}}, 1'b1};

  state_e            r_state;
  state_e            w_state_nxt;
  logic [N_BITS-1:0] r_x_hold;
  logic [2:0]        r_cnt;
  logic              r_ovf;
  logic              r_load;
  logic              r_add;
  logic              r_shift;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic w_pair_nz;
  logic w_do_add;
  logic w_do_shift;
  logic w_last;

  assign w_pair_nz = i_y_pair[1] ^ i_y_pair[0];
  assign w_last    = (r_cnt == LastIter);

`ifdef BOOTH_ZERO_SKIP_EN
  // An add slot with a 00/11 pair turns straight into the shift for that iteration.
  assign w_do_add   = r_add & w_pair_nz;
  assign w_do_shift = r_shift | (r_add & ~w_pair_nz);
`else
  assign w_do_add   = r_add;
  assign w_do_shift = r_shift;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = StLoad;
      StLoad:  w_state_nxt = StAdd;
      StAdd, StShift: begin
        if (w_do_shift) w_state_nxt = w_last ? StDone : StAdd;
        else            w_state_nxt = StShift;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Strobes are registered from the next state, so they track the current state exactly.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= StIdle;
      r_x_hold <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_load   <= 1'b0;
      r_add    <= 1'b0;
      r_shift  <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_load  <= (w_state_nxt == StLoad);
      r_add   <= (w_state_nxt == StAdd);
      r_shift <= (w_state_nxt == StShift);
      r_ready <= (w_state_nxt == StIdle);
      r_busy  <= (w_state_nxt != StIdle);
      r_done  <= (w_state_nxt == StDone);
      // Operand and overflow flag are captured on entry so they are valid during LOAD.
      if (w_state_nxt == StLoad) begin
        r_x_hold <= i_x;
        r_cnt    <= '0;
        r_ovf    <= (i_x == MinNeg);
      end else if (w_do_shift) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    o_x_adder = '0;
    if (w_do_add) begin
      unique case (i_y_pair)
        2'b01:   o_x_adder = r_x_hold;
        2'b10:   o_x_adder = ~r_x_hold + One;
        default: o_x_adder = '0;
      endcase
    end
  end

  assign o_ldx     = r_load;
  assign o_ldy     = r_load;
  assign o_rst_p   = r_load;
  assign o_ldp     = w_do_add;
  assign o_shift_y = w_do_shift;
  assign o_shift_p = w_do_shift;
  assign o_ready   = r_ready;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_booth_controller.sv
// Directed bench for booth_controller with a small Booth datapath model driving y_pair.
module tb_booth_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] x_in;
  logic [5:0] tb_y;
  logic [1:0] y_pair;
  logic       ldx, ldy, rst_p, ldp, shift_y, shift_p;
  logic [5:0] x_adder;
  logic       ready, busy, done, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  booth_controller #(.N_BITS(6)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_x       (x_in),
    .i_y_pair  (y_pair),
    .o_ldx     (ldx),
    .o_ldy     (ldy),
    .o_rst_p   (rst_p),
    .o_ldp     (ldp),
    .o_shift_y (shift_y),
    .o_shift_p (shift_p),
    .o_x_adder (x_adder),
    .o_ready   (ready),
    .o_busy    (busy),
    .o_done    (done),
    .o_ovf     (ovf)
  );

  // Datapath: Y holds {y, y[-1]}, P is the 12-bit product register.
  logic [6:0]  m_y;
  logic [11:0] m_p;
  always_ff @(posedge clk) begin
    if (ldy) m_y <= {tb_y, 1'b0};
    else if (shift_y) m_y <= {m_y[6], m_y[6:1]};
    if (rst_p) m_p <= '0;
    else if (ldp) m_p[11:6] <= m_p[11:6] + x_adder;
    else if (shift_p) m_p <= {m_p[11], m_p[11:1]};
  end
  assign y_pair = m_y[1:0];

  int          op_done_cyc, op_done_cnt, op_ldp_cnt, op_stray;
  logic        op_load_ok, op_ovf_load, op_ovf_done, op_ready_after, op_busy_after;
  logic [11:0] op_res;
  logic [5:0]  op_xa [6];

  // Starts an op from IDLE; extra[k] is the start level driven during cycle k.
  task automatic run_op(input logic [5:0] xv, input logic [5:0] yv, input logic [31:0] extra);
    op_done_cyc = -1; op_done_cnt = 0; op_ldp_cnt = 0; op_stray = 0;
    op_load_ok = 1'b0; op_ovf_load = 1'bx; op_ovf_done = 1'bx;
    op_ready_after = 1'b0; op_busy_after = 1'b1; op_res = 'x;
    for (int i = 0; i < 6; i++) op_xa[i] = 6'h2A;
    x_in = xv; tb_y = yv; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        op_load_ok  = ldx & ldy & rst_p & busy & ~ready & ~ldp & ~shift_p;
        op_ovf_load = ovf;
      end
      if (x_adder != 6'd0 && !ldp) op_stray++;
      if (ldp) begin
        if (op_ldp_cnt < 6) op_xa[op_ldp_cnt] = x_adder;
        op_ldp_cnt++;
      end
      if (done) begin
        op_done_cnt++;
        if (op_done_cyc < 0) begin
          op_done_cyc = k; op_res = m_p; op_ovf_done = ovf;
        end
      end
      start = (k < 32) ? extra[k] : 1'b0;
      if (op_done_cyc >= 0 && k == op_done_cyc + 1) begin
        op_ready_after = ready; op_busy_after = busy;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; x_in = '0; tb_y = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_checks++; if ({busy, done, ovf} !== 3'b000) begin
      n_fail++; $display("FAIL reset_status: got %b want 000", {busy, done, ovf}); end
    n_checks++; if ({ldx, ldy, rst_p, ldp, shift_y, shift_p} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000000", {ldx, ldy, rst_p, ldp, shift_y, shift_p}); end
    n_checks++; if (x_adder !== 6'd0) begin n_fail++; $display("FAIL reset_x_adder: got %h want 00", x_adder); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: ready %b busy %b want 1 0", ready, busy); end
  endtask

  task automatic test_basic();
    logic [5:0] exp_xa [6];
    exp_xa = '{6'h3D, 6'h03, 6'h3D, 6'h03, 6'h00, 6'h00};
    run_op(6'd3, 6'd5, 32'h0);
    n_checks++; if (op_load_ok !== 1'b1) begin n_fail++; $display("FAIL basic_load_strobes: got %b want 1", op_load_ok); end
    n_checks++; if (op_done_cyc != 14) begin n_fail++; $display("FAIL basic_latency: got %0d want 14", op_done_cyc); end
    n_checks++; if (op_res !== 12'd15) begin n_fail++; $display("FAIL basic_result: got %h want 00f", op_res); end
    n_checks++; if (op_ovf_done !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b want 0", op_ovf_done); end
    n_checks++; if (op_ldp_cnt != 6) begin n_fail++; $display("FAIL basic_ldp_count: got %0d want 6", op_ldp_cnt); end
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (op_xa[i] !== exp_xa[i]) begin
        n_fail++; $display("FAIL basic_x_adder[%0d]: got %h want %h", i, op_xa[i], exp_xa[i]); end
    end
    n_checks++; if (op_stray != 0) begin n_fail++; $display("FAIL x_adder_outside_add: got %0d want 0", op_stray); end
    n_checks++; if (op_ready_after !== 1'b1 || op_busy_after !== 1'b0) begin
      n_fail++; $display("FAIL basic_ready_after: ready %b busy %b want 1 0", op_ready_after, op_busy_after); end
  endtask

  task automatic test_signed();
    run_op(6'h39, 6'd9, 32'h0);  // -7 * 9
    n_checks++; if (op_res !== 12'hFC1) begin n_fail++; $display("FAIL signed_m7x9: got %h want fc1", op_res); end
    n_checks++; if (op_done_cyc != 14) begin n_fail++; $display("FAIL signed_latency: got %0d want 14", op_done_cyc); end
    run_op(6'd31, 6'h21, 32'h0);  // 31 * -31
    n_checks++; if (op_res !== 12'hC3F) begin n_fail++; $display("FAIL signed_31xm31: got %h want c3f", op_res); end
  endtask

  task automatic test_ovf();
    run_op(6'h20, 6'd1, 32'h0);  // -32 * 1
    n_checks++; if (op_done_cyc != 14) begin n_fail++; $display("FAIL ovf_latency: got %0d want 14", op_done_cyc); end
    n_checks++; if (op_ovf_done !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", op_ovf_done); end
    @(posedge clk); #1;
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    run_op(6'd2, 6'd2, 32'h0);
    n_checks++; if (op_ovf_load !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_load: got %b want 0", op_ovf_load); end
    n_checks++; if (op_res !== 12'd4) begin n_fail++; $display("FAIL ovf_next_result: got %h want 004", op_res); end
  endtask

  task automatic test_busy_start();
    run_op(6'd3, 6'd5, 32'h0000_4020);  // start pulses in cycles 5 and 14
    n_checks++; if (op_done_cnt != 1) begin n_fail++; $display("FAIL busy_done_count: got %0d want 1", op_done_cnt); end
    n_checks++; if (op_done_cyc != 14) begin n_fail++; $display("FAIL busy_latency: got %0d want 14", op_done_cyc); end
    n_checks++; if (op_ready_after !== 1'b1) begin n_fail++; $display("FAIL busy_ready15: got %b want 1", op_ready_after); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL busy_no_queue: busy %b ready %b want 0 1", busy, ready); end
  endtask

  task automatic test_back_to_back();
    int d2;
    run_op(6'd3, 6'd5, 32'h0000_FFFE);  // start held through DONE and IDLE
    n_checks++; if (op_ready_after !== 1'b1) begin n_fail++; $display("FAIL b2b_idle15: got %b want 1", op_ready_after); end
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (ldx !== 1'b1) begin n_fail++; $display("FAIL b2b_load16: got %b want 1", ldx); end
    d2 = -1;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (done) begin d2 = j; break; end
    end
    n_checks++; if (d2 != 13) begin n_fail++; $display("FAIL b2b_latency: got %0d want 13", d2); end
    n_checks++; if (m_p !== 12'd15) begin n_fail++; $display("FAIL b2b_result: got %h want 00f", m_p); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    int seen_done;
    x_in = 6'd3; tb_y = 6'd5; start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b0;  // low during cycle 7
    @(posedge clk); #1;
    n_checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle: ready %b busy %b done %b want 1 0 0", ready, busy, done); end
    n_checks++; if ({ldx, ldy, rst_p, ldp, shift_y, shift_p, x_adder} !== 12'h000) begin
      n_fail++; $display("FAIL rst_mid_strobes: got %h want 000", {ldx, ldy, rst_p, ldp, shift_y, shift_p, x_adder}); end
    rst = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d want 0", seen_done); end
    run_op(6'h39, 6'd9, 32'h0);
    n_checks++; if (op_res !== 12'hFC1) begin n_fail++; $display("FAIL rst_mid_fresh: got %h want fc1", op_res); end
  endtask

`ifdef BOOTH_ZERO_SKIP_EN
  task automatic test_zero_skip();
    run_op(6'd5, 6'd0, 32'h0);
    n_checks++; if (op_ldp_cnt != 0) begin n_fail++; $display("FAIL skip_ldp_y0: got %0d want 0", op_ldp_cnt); end
    n_checks++; if (op_done_cyc != 8) begin n_fail++; $display("FAIL skip_latency_y0: got %0d want 8", op_done_cyc); end
    n_checks++; if (op_res !== 12'd0) begin n_fail++; $display("FAIL skip_result_y0: got %h want 000", op_res); end
    run_op(6'd5, 6'h3F, 32'h0);
    n_checks++; if (op_done_cyc != 9) begin n_fail++; $display("FAIL skip_latency_ym1: got %0d want 9", op_done_cyc); end
    n_checks++; if (op_res !== 12'hFFB) begin n_fail++; $display("FAIL skip_result_ym1: got %h want ffb", op_res); end
  endtask
`else
  task automatic test_fixed_latency();
    run_op(6'd5, 6'd0, 32'h0);
    n_checks++; if (op_ldp_cnt != 6) begin n_fail++; $display("FAIL fixed_ldp_y0: got %0d want 6", op_ldp_cnt); end
    n_checks++; if (op_done_cyc != 14) begin n_fail++; $display("FAIL fixed_latency_y0: got %0d want 14", op_done_cyc); end
    n_checks++; if (op_res !== 12'd0) begin n_fail++; $display("FAIL fixed_result_y0: got %h want 000", op_res); end
    run_op(6'd5, 6'h3F, 32'h0);
    n_checks++; if (op_done_cyc != 14) begin n_fail++; $display("FAIL fixed_latency_ym1: got %0d want 14", op_done_cyc); end
    n_checks++; if (op_res !== 12'hFFB) begin n_fail++; $display("FAIL fixed_result_ym1: got %h want ffb", op_res); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_ovf();
    test_busy_start();
    test_back_to_back();
    test_rst_mid();
`ifdef BOOTH_ZERO_SKIP_EN
    test_zero_skip();
`else
    test_fixed_latency();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
